// File: rtl/i2s_pkg.sv
// i2s_pkg: shared I2S widths, frame-position type and stereo sample struct
package i2s_pkg;
    localparam int I2S_SAMPLE_W = 16;
    localparam int I2S_SLOT_W = 16;
    localparam int I2S_POS_W = $clog2(2 * I2S_SLOT_W);
    typedef logic [I2S_POS_W-1:0] i2s_pos_t;
    typedef struct packed {
        logic [I2S_SAMPLE_W-1:0] left;
        logic [I2S_SAMPLE_W-1:0] right;
    } i2s_stereo_t;
endpackage

// File: rtl/i2s_bclk_gen.sv
// i2s_bclk_gen: clk divider producing BCLK and a one-clk strobe on each BCLK falling event
module i2s_bclk_gen #(
    parameter int CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    output logic bclk_o,
    output logic fall_evt_o
);
    localparam int CW = CLK_DIV > 1 ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(CLK_DIV - 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic bclk_q, bclk_d, tc;
    // divider wraps at terminal count and toggles bclk; everything parks at zero while disabled
    always_comb begin
        tc = en_i && (cnt_q == TC);
        cnt_d = (!en_i || tc) ? '0 : cnt_q + 1'b1;
        bclk_d = en_i && (bclk_q ^ tc);
    end
    // divider and bclk state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            bclk_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            bclk_q <= bclk_d;
        end
    end
    assign bclk_o = bclk_q;
    assign fall_evt_o = tc && bclk_q;
endmodule

// File: rtl/i2s_tx.sv
// i2s_tx: I2S master transmitter, mono sample sent in both slots; I2S_TX_UNDERRUN_CNT_EN adds underrun_cnt
module i2s_tx
    import i2s_pkg::*;
#(
    parameter int CLK_DIV = 4,
    parameter int SAMPLE_W = I2S_SAMPLE_W,
    parameter int SLOT_W = I2S_SLOT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] s_data,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                i2s_bclk,
    output logic                i2s_ws,
    output logic                i2s_sd,
    output logic                underrun
`ifdef I2S_TX_UNDERRUN_CNT_EN
    ,
    output logic [15:0]         underrun_cnt
`endif
);
    localparam int FW = 2 * SLOT_W;
    localparam int PW = $clog2(FW);
    localparam logic [PW-1:0] P_LAST = PW'(FW - 1);
    localparam logic [PW-1:0] WS_LO = PW'(SLOT_W - 1);
    localparam logic [PW-1:0] WS_HI = PW'(FW - 2);
    logic [PW-1:0] p_q, p_d;
    logic [FW-1:0] f_q, f_d;
    logic [SAMPLE_W-1:0] hold_q, hold_d;
    logic [SLOT_W-1:0] slot;
    logic full_q, full_d, en_q, ws_q, ws_d, sd_q, sd_d, uf_q, uf_d;
    logic fall, start;

    i2s_bclk_gen #(.CLK_DIV(CLK_DIV)) u_bclk (
        .clk       (clk),
        .rst       (rst),
        .en_i      (en),
        .bclk_o    (i2s_bclk),
        .fall_evt_o(fall)
    );

    // frame start on enable rising or on p wrapping; F is shifted so f_q[0] is always the next bit
    always_comb begin
        slot = '0;
        for (int i = 0; i < SAMPLE_W; i++) slot[i] = hold_q[SAMPLE_W-1-i];
        start = en && (!en_q || (fall && p_q == P_LAST));
        p_d = (!en || start) ? '0 : fall ? p_q + 1'b1 : p_q;
        f_d = !en ? '0 : start ? (full_q ? {slot, slot} : '0) : fall ? f_q >> 1 : f_q;
        sd_d = !en ? 1'b0 : fall ? f_q[0] : sd_q;
        ws_d = !en ? 1'b0 : fall ? (p_d >= WS_LO && p_d <= WS_HI) : ws_q;
        uf_d = start && !full_q;
        full_d = full_q ? !start : s_valid;
        hold_d = (!full_q && s_valid) ? s_data : hold_q;
    end

    // frame, output and holding-register state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            p_q <= '0;
            f_q <= '0;
            sd_q <= 1'b0;
            ws_q <= 1'b0;
            uf_q <= 1'b0;
            en_q <= 1'b0;
            full_q <= 1'b0;
            hold_q <= '0;
        end else begin
            p_q <= p_d;
            f_q <= f_d;
            sd_q <= sd_d;
            ws_q <= ws_d;
            uf_q <= uf_d;
            en_q <= en;
            full_q <= full_d;
            hold_q <= hold_d;
        end
    end

    assign s_ready = !full_q;
    assign i2s_ws = ws_q;
    assign i2s_sd = sd_q;
    assign underrun = uf_q;

`ifdef I2S_TX_UNDERRUN_CNT_EN
    logic [15:0] ucnt_q, ucnt_d;
    // saturating underrun tally, cleared only by reset
    always_comb ucnt_d = (uf_d && ucnt_q != 16'hFFFF) ? ucnt_q + 1'b1 : ucnt_q;
    // underrun counter register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ucnt_q <= '0;
        else ucnt_q <= ucnt_d;
    end
    assign underrun_cnt = ucnt_q;
`endif
endmodule
